// File: rtl/barrett_req_sched.sv
// Round-robin front end for a shared pipelined Barrett reduction datapath:
// arbitrates requesters, owns the modulus config, tags in-flight ops and applies the final subtract.
module barrett_req_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*128-1:0]  req_z,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 cfg_valid,
  input  logic [63:0]          cfg_q,
  input  logic [30:0]          cfg_mu,
  input  logic [7:0]           cfg_k,
  output logic                 cfg_ready,
  output logic                 dp_valid,
  output logic [127:0]         dp_z,
  output logic [63:0]          dp_q,
  output logic [30:0]          dp_mu,
  output logic [7:0]           dp_k,
  input  logic [63:0]          dp_t,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [63:0]          rsp_t,
  output logic                 busy
);

  localparam int unsigned ZW = 128;
  localparam int unsigned CW = $clog2(LAT + 1);
  localparam int unsigned TW = LAT * IDW;

  typedef enum logic [1:0] {UNCFG, RUN, DRAIN, LOAD} state_t;

  state_t          state, state_n;
  logic [IDW-1:0]  ptr, gnt_id;
  logic [NREQ-1:0] gnt;
  logic            found, launch, ret, load;
  int unsigned     idx;
  logic [ZW-1:0]   z_sel;
  logic [CW-1:0]   cnt, cnt_n;
  logic [LAT-1:0]  tag_v;
  logic [TW-1:0]   tag_id;

  // Round-robin search starting at ptr; grants are suppressed outside RUN and while a cfg request is pending
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    if (state == RUN && !cfg_valid) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        idx = (32'(ptr) + i) % NREQ;
        if (!found && req_valid[IDW'(idx)]) begin
          found  = 1'b1;
          gnt_id = IDW'(idx);
        end
      end
      gnt[gnt_id] = found;
    end
  end

  assign req_ready = gnt;
  assign launch    = found;
  assign ret       = tag_v[LAT-1];

  always_comb begin
    z_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) z_sel = req_z[i*ZW +: ZW];
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      UNCFG:   if (cfg_valid) state_n = LOAD;
      RUN:     if (cfg_valid) state_n = DRAIN;
      DRAIN:   if (cnt == '0) state_n = LOAD;
      LOAD:    state_n = RUN;
      default: state_n = UNCFG;
    endcase
  end

  // LOAD lasts exactly one cycle, so entry into it is the config-latch strobe
  assign load = (state_n == LOAD);

  always_comb begin
    cnt_n = cnt;
    if (launch && !ret)      cnt_n = cnt + CW'(1);
    else if (!launch && ret) cnt_n = cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= UNCFG;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      cnt       <= '0;
      tag_v     <= '0;
      tag_id    <= '0;
      cfg_ready <= 1'b0;
      dp_valid  <= 1'b0;
      dp_z      <= '0;
      dp_q      <= '0;
      dp_mu     <= '0;
      dp_k      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_t     <= '0;
      busy      <= 1'b1;
    end else begin
      cnt       <= cnt_n;
      cfg_ready <= load;
      dp_valid  <= launch;
      busy      <= (cnt_n != '0) || (state_n != RUN);
      if (load) begin
        dp_q  <= cfg_q;
        dp_mu <= cfg_mu;
        dp_k  <= cfg_k;
      end
      if (launch) begin
        dp_z <= z_sel;
        ptr  <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
      end
      // Tag pipe mirrors the datapath so the owner id lines up with dp_t
      tag_v  <= (tag_v << 1) | LAT'(launch);
      tag_id <= (tag_id << IDW) | TW'(gnt_id);
      rsp_valid <= ret;
      if (ret) begin
        rsp_id <= tag_id[TW-1 -: IDW];
        rsp_t  <= (dp_t >= dp_q) ? dp_t - dp_q : dp_t;
      end
    end
  end

endmodule

// File: tb/tb_barrett_req_sched.sv
// Scoreboard bench for barrett_req_sched: directed grants push expected {id, t}; a monitor checks every rsp.
module tb_barrett_req_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 4;
  localparam int unsigned IDW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*128-1:0] req_z;
  logic [NREQ-1:0]     req_ready;
  logic                cfg_valid;
  logic [63:0]         cfg_q;
  logic [30:0]         cfg_mu;
  logic [7:0]          cfg_k;
  logic                cfg_ready;
  logic                dp_valid;
  logic [127:0]        dp_z;
  logic [63:0]         dp_q;
  logic [30:0]         dp_mu;
  logic [7:0]          dp_k;
  logic [63:0]         dp_t;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [63:0]         rsp_t;
  logic                busy;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [63:0]    t;
  } exp_t;

  exp_t        exp_q[$];
  int          hs_q[$];
  exp_t        e;
  int          h;
  int          cyc = 0;
  int          last_rsp_cyc = 0;
  int          checks = 0;
  int          passed = 0;
  logic [63:0] pipe [LAT-1];

  barrett_req_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_z(req_z), .req_ready(req_ready),
    .cfg_valid(cfg_valid), .cfg_q(cfg_q), .cfg_mu(cfg_mu), .cfg_k(cfg_k), .cfg_ready(cfg_ready),
    .dp_valid(dp_valid), .dp_z(dp_z), .dp_q(dp_q), .dp_mu(dp_mu), .dp_k(dp_k), .dp_t(dp_t),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_t(rsp_t), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: raw result is the low 64 bits of z, ready to be sampled LAT edges after launch
  always @(posedge clk) begin
    pipe[0] <= dp_z[63:0];
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_t = pipe[LAT-2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Record the edge that completes each handshake, for the latency check
  always @(negedge clk) begin
    if (!rst && (req_valid & req_ready) != '0) hs_q.push_back(cyc + 1);
  end

  always @(negedge clk) begin
    if (rsp_valid) begin
      last_rsp_cyc = cyc;
      chk("rsp_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_t", rsp_t, e.t);
      end
      if (hs_q.size() != 0) begin
        h = hs_q.pop_front();
        chk("rsp_latency", 64'(cyc - h), 64'(LAT));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_z(input int lane, input logic [63:0] v);
    req_z[lane*128 +: 128] = {64'd0, v};
  endtask

  task automatic cycle_chk(input logic [NREQ-1:0] rv, input logic [NREQ-1:0] eg,
                           input int eid, input logic [63:0] et, input string nm);
    req_valid = rv;
    @(negedge clk);
    chk(nm, 64'(req_ready), 64'(eg));
    if (eg != '0) exp_q.push_back('{id: IDW'(eid), t: et});
    tick();
  endtask

  task automatic apply_cfg(input logic [63:0] q, input logic [30:0] mu, input logic [7:0] k);
    cfg_q = q; cfg_mu = mu; cfg_k = k; cfg_valid = 1'b1;
  endtask

  initial begin
    logic [NREQ-1:0] g1111 [8];
    logic [63:0]     lane_t [NREQ];
    logic [NREQ-1:0] g1010 [7];
    int              id1010 [7];
    bit              got;

    rst = 1'b1; req_valid = '0; req_z = '0;
    cfg_valid = 1'b0; cfg_q = '0; cfg_mu = '0; cfg_k = '0;
    tick(); tick();
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_cfg_ready", 64'(cfg_ready), 64'(0));
    chk("rst_dp_valid", 64'(dp_valid), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_dp_q", dp_q, 64'(0));
    chk("rst_rsp_t", rsp_t, 64'(0));
    chk("rst_busy", 64'(busy), 64'(1));
    rst = 1'b0;

    // Unconfigured: a pending request must not be granted
    req_valid = 4'b0001; set_z(0, 150);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("uncfg_no_gnt", 64'(req_ready), 64'(0));
      chk("uncfg_no_dp", 64'(dp_valid), 64'(0));
      tick();
    end
    apply_cfg(97, 168, 7);
    @(negedge clk);
    chk("cfg_pending_no_gnt", 64'(req_ready), 64'(0));
    tick();
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("cfg_ready_pulse", 64'(cfg_ready), 64'(1));
    chk("cfg_dp_q", dp_q, 64'(97));
    chk("cfg_dp_mu", 64'(dp_mu), 64'(168));
    chk("cfg_dp_k", 64'(dp_k), 64'(7));
    chk("load_no_gnt", 64'(req_ready), 64'(0));
    tick();
    chk("cfg_ready_drop", 64'(cfg_ready), 64'(0));

    // Final-subtract corner cases with q=97
    set_z(0, 150); cycle_chk(4'b0001, 4'b0001, 0, 53, "corr_gnt");
    set_z(0, 96);  cycle_chk(4'b0001, 4'b0001, 0, 96, "corr_gnt");
    set_z(0, 97);  cycle_chk(4'b0001, 4'b0001, 0, 0,  "corr_gnt");
    set_z(0, 0);   cycle_chk(4'b0001, 4'b0001, 0, 0,  "corr_gnt");
    req_valid = '0;
    repeat (6) tick();
    chk("idle_busy", 64'(busy), 64'(0));

    // Lane raw values 10,150,97,193 reduce to 10,53,0,96; first move ptr to 0 via lane 3
    set_z(0, 10); set_z(1, 150); set_z(2, 97); set_z(3, 193);
    lane_t = '{64'd10, 64'd53, 64'd0, 64'd96};
    cycle_chk(4'b1000, 4'b1000, 3, 96, "ptr_to0_gnt");
    g1111 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int k = 0; k < 8; k++) begin
      cycle_chk(4'b1111, g1111[k], k % 4, lane_t[k % 4], "rr1111_gnt");
      chk("rr1111_dp_valid", 64'(dp_valid), 64'(1));
    end

    g1010  = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
    id1010 = '{1, 3, 1, 3, 3, 3, 3};
    for (int k = 0; k < 7; k++)
      cycle_chk((k < 4) ? 4'b1010 : 4'b1000, g1010[k], id1010[k], lane_t[id1010[k]], "rr1010_gnt");
    req_valid = '0;
    repeat (6) tick();

    // Reconfigure with three ops in flight: they finish with q=97, the next uses q=101
    set_z(0, 150); cycle_chk(4'b0001, 4'b0001, 0, 53, "drain_pre_gnt");
    set_z(0, 96);  cycle_chk(4'b0001, 4'b0001, 0, 96, "drain_pre_gnt");
    set_z(0, 120); cycle_chk(4'b0001, 4'b0001, 0, 23, "drain_pre_gnt");
    set_z(0, 150);
    apply_cfg(101, 162, 7);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (cfg_ready) begin
        got = 1'b1;
        cfg_valid = 1'b0;
        chk("cfgrdy_after_last_rsp", 64'(cyc - last_rsp_cyc), 64'(1));
        chk("drain_new_q", dp_q, 64'(101));
        chk("drain_load_no_gnt", 64'(req_ready), 64'(0));
      end else begin
        chk("drain_no_gnt", 64'(req_ready), 64'(0));
      end
      tick();
    end
    chk("drain_cfg_ready_seen", 64'(got), 64'(1));
    cycle_chk(4'b0001, 4'b0001, 0, 49, "newq_gnt");
    req_valid = '0;
    repeat (6) tick();

    // Reset two cycles after a handshake: that op must never answer
    set_z(2, 97);
    cycle_chk(4'b0100, 4'b0100, 2, 0, "pre_rst_gnt");
    exp_q.pop_back();
    req_valid = '0;
    tick();
    rst = 1'b1;
    exp_q.delete(); hs_q.delete();
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    for (int n = 0; n < LAT + 2; n++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 64'(rsp_valid), 64'(0));
      chk("post_rst_busy", 64'(busy), 64'(1));
      chk("post_rst_no_gnt", 64'(req_ready), 64'(0));
      tick();
    end
    apply_cfg(97, 168, 7);
    tick();
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("recfg_ready", 64'(cfg_ready), 64'(1));
    tick();
    set_z(0, 10);
    cycle_chk(4'b1111, 4'b0001, 0, 10, "post_rst_gnt");
    req_valid = '0;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    tick(); tick();
    chk("final_busy", 64'(busy), 64'(0));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
